// File: rtl/fan_if.sv
// Controller/actuator bundle for fan_driver: requests and tach in, drives and status out.
interface fan_if;
    logic       cooler;
    logic       heater;
    logic [3:0] rps;
    logic       tach;
    logic       cooler_drive;
    logic       heater_drive;
    logic       fan_pwm;
    logic [3:0] cur_rps;
    logic       fault;

    modport master (
        output cooler, heater, rps, tach,
        input  cooler_drive, heater_drive, fan_pwm, cur_rps, fault
    );

    modport slave (
        input  cooler, heater, rps, tach,
        output cooler_drive, heater_drive, fan_pwm, cur_rps, fault
    );
endinterface

// File: rtl/fan_driver.sv
// Heater/cooler interlock with dead time, ramped fan speed and PWM fan drive.
// Optional tach stall detection is built when FAN_TACH_STALL_EN is defined.
module fan_driver #(
    parameter int unsigned RAMP_DIV    = 4,
    parameter int unsigned DEAD_CYCLES = 3,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic clock,
    input  logic reset,
    fan_if.slave bus
);
    localparam int unsigned DW   = $clog2(DEAD_CYCLES + 1);
    localparam int unsigned DIVW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    typedef enum logic [1:0] {IDLE, HEAT, COOL, DEAD} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dead_q, dead_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [3:0]      pwm_q, pwm_d;
    logic [3:0]      cur_q, cur_d;
    logic [3:0]      target;
    logic            step;
    logic            cooler_drive_q, heater_drive_q, fan_pwm_q, fault_q;
    logic            stall_q, stall_d;

    logic req_heat, req_cool, conflict;
    assign req_heat = bus.heater & ~bus.cooler;
    assign req_cool = bus.cooler & ~bus.heater;
    assign conflict = bus.heater & bus.cooler;

    // Interlock FSM: DEAD counts down from DEAD_CYCLES and exits on the cycle it reads zero
    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        case (state_q)
            IDLE: begin
                if (req_heat)      state_d = HEAT;
                else if (req_cool) state_d = COOL;
            end
            HEAT: begin
                if (!req_heat) begin
                    state_d = DEAD;
                    dead_d  = DW'(DEAD_CYCLES);
                end
            end
            COOL: begin
                if (!req_cool) begin
                    state_d = DEAD;
                    dead_d  = DW'(DEAD_CYCLES);
                end
            end
            DEAD: begin
                if (dead_q == '0) begin
                    if (req_heat)      state_d = HEAT;
                    else if (req_cool) state_d = COOL;
                    else               state_d = IDLE;
                end else begin
                    dead_d = dead_q - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FAN_TACH_STALL_EN
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

    logic          tach_q;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles without a tach rising edge while the fan is commanded to spin
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((bus.tach && !tach_q) || (cur_q == 4'd0))
            stall_cnt_d = '0;
        else if (stall_cnt_q != SW'(STALL_LIMIT))
            stall_cnt_d = stall_cnt_q + SW'(1);
        stall_d = stall_q | (stall_cnt_d == SW'(STALL_LIMIT));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tach_q      <= 1'b0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            tach_q      <= bus.tach;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end
`else
    logic unused_tach;
    assign unused_tach = bus.tach;
    assign stall_d     = 1'b0;
    assign stall_q     = 1'b0;
`endif

    // Speed ramp: one step toward target per divider wrap, forced to 0 on stall
    always_comb begin
        target = (state_q == COOL && !stall_q) ? bus.rps : 4'd0;
        step   = (div_q == DIVW'(RAMP_DIV - 1));
        div_d  = step ? '0 : div_q + DIVW'(1);
        pwm_d  = (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
        cur_d  = cur_q;
        if (step) begin
            if (cur_q < target)      cur_d = cur_q + 4'd1;
            else if (cur_q > target) cur_d = cur_q - 4'd1;
        end
        if (stall_d) cur_d = 4'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            dead_q         <= '0;
            div_q          <= '0;
            pwm_q          <= 4'd0;
            cur_q          <= 4'd0;
            cooler_drive_q <= 1'b0;
            heater_drive_q <= 1'b0;
            fan_pwm_q      <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            dead_q         <= dead_d;
            div_q          <= div_d;
            pwm_q          <= pwm_d;
            cur_q          <= cur_d;
            cooler_drive_q <= (state_d == COOL);
            heater_drive_q <= (state_d == HEAT);
            fan_pwm_q      <= (pwm_q < cur_q) && !stall_d;
            fault_q        <= conflict | stall_d;
        end
    end

    assign bus.cooler_drive = cooler_drive_q;
    assign bus.heater_drive = heater_drive_q;
    assign bus.fan_pwm      = fan_pwm_q;
    assign bus.cur_rps      = cur_q;
    assign bus.fault        = fault_q;
endmodule

// File: tb/tb_fan_driver.sv
// Directed bench for fan_driver with RAMP_DIV=4, DEAD_CYCLES=3.
module tb_fan_driver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fan_if bus ();

    fan_driver #(.RAMP_DIV(4), .DEAD_CYCLES(3), .STALL_LIMIT(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [7:0] outs;
    assign outs = {bus.cooler_drive, bus.heater_drive, bus.fan_pwm, bus.cur_rps, bus.fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int last_chg;
        int nchg;
        int highs;
        int rise_k;
        int both;
        logic [3:0] prev;

        bus.cooler = 1'b0;
        bus.heater = 1'b0;
        bus.rps    = 4'd0;
        bus.tach   = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            bus.cooler = 1'($urandom_range(0, 1));
            bus.heater = 1'($urandom_range(0, 1));
            bus.rps    = 4'($urandom_range(0, 15));
            bus.tach   = 1'($urandom_range(0, 1));
            tick();
            check("reset_outs", 32'(outs), 32'd0);
        end
        bus.cooler = 1'b0;
        bus.heater = 1'b0;
        bus.tach   = 1'b0;
        reset      = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("idle_outs", 32'(outs), 32'd0);

        // Cool at rps=8: drive after 1 clock, ramp in 4-clock steps
        bus.cooler = 1'b1;
        bus.rps    = 4'd8;
        tick();
        check("cool_drive", 32'(bus.cooler_drive), 32'd1);
        check("cool_heat_off", 32'(bus.heater_drive), 32'd0);
        prev = bus.cur_rps;
        nchg = 0;
        last_chg = 0;
        for (int i = 1; i <= 60 && bus.cur_rps != 4'd8; i++) begin
            tick();
            if (bus.cur_rps != prev) begin
                if (nchg > 0) check("ramp_up_interval", 32'(i - last_chg), 32'd4);
                check("ramp_up_delta", 32'(bus.cur_rps), 32'(prev + 4'd1));
                nchg++;
                last_chg = i;
                prev = bus.cur_rps;
            end
        end
        check("ramp_up_final", 32'(bus.cur_rps), 32'd8);
        check("ramp_up_time", 32'(last_chg >= 29 && last_chg <= 33), 32'd1);
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.fan_pwm) highs++;
        end
        check("pwm_duty8", 32'(highs), 32'd8);
        check("hold_rps8", 32'(bus.cur_rps), 32'd8);

        // Drop cooler: drive off after 1 clock, DEAD, ramp back to 0
        bus.cooler = 1'b0;
        tick();
        check("cool_drop", 32'(bus.cooler_drive), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dead_drives", 32'({bus.cooler_drive, bus.heater_drive}), 32'd0);
        end
        for (int i = 0; i < 60 && bus.cur_rps != 4'd0; i++) tick();
        check("ramp_down_final", 32'(bus.cur_rps), 32'd0);
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.fan_pwm) highs++;
        end
        check("pwm_zero", 32'(highs), 32'd0);

        // Direct cooler -> heater swap
        bus.cooler = 1'b1;
        tick();
        check("swap_cool_on", 32'(bus.cooler_drive), 32'd1);
        bus.cooler = 1'b0;
        bus.heater = 1'b1;
        tick();
        check("swap_cool_off", 32'(bus.cooler_drive), 32'd0);
        rise_k = 0;
        both = 0;
        for (int k = 1; k <= 10 && rise_k == 0; k++) begin
            tick();
            if (bus.cooler_drive && bus.heater_drive) both++;
            if (bus.heater_drive) rise_k = k;
        end
        check("swap_delay", 32'(rise_k), 32'd4);
        check("swap_never_both", 32'(both), 32'd0);

        // Conflict for 5 clocks from HEAT
        bus.cooler = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("conflict_fault", 32'(bus.fault), 32'd1);
            check("conflict_drives", 32'({bus.cooler_drive, bus.heater_drive}), 32'd0);
        end
        bus.cooler = 1'b0;
        bus.heater = 1'b0;
        tick();
        check("conflict_clear", 32'(bus.fault), 32'd0);
        for (int i = 0; i < 6; i++) tick();

        // Reset mid-ramp: asynchronous zeroing, resume from IDLE
        bus.cooler = 1'b1;
        bus.rps    = 4'd15;
        for (int i = 0; i < 20; i++) tick();
        check("midramp_nonzero", 32'(bus.cur_rps != 4'd0), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset", 32'(outs), 32'd0);
        bus.cooler = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("post_reset_idle", 32'(outs), 32'd0);
        bus.cooler = 1'b1;
        bus.rps    = 4'd3;
        tick();
        check("resume_drive", 32'(bus.cooler_drive), 32'd1);
        check("resume_cur0", 32'(bus.cur_rps), 32'd0);

`ifdef FAN_TACH_STALL_EN
        bus.rps  = 4'd15;
        bus.tach = 1'b0;
        for (int i = 0; i < 300 && !bus.fault; i++) tick();
        check("stall_fault", 32'(bus.fault), 32'd1);
        tick();
        check("stall_cur0", 32'(bus.cur_rps), 32'd0);
        check("stall_pwm0", 32'(bus.fan_pwm), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.tach = 1'b1;
            tick();
            bus.tach = 1'b0;
            tick();
        end
        check("stall_sticky", 32'({bus.fault, bus.cur_rps}), 32'h10);
        bus.cooler = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("stall_reset", 32'(bus.fault), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
